// File: rtl/ram_pkg.sv
// Shared widths and types for the dual-port RAM slice.
// Imported by the tracker and the top.
package ram_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W:0]   cnt_t;

endpackage

// File: rtl/ram_valid_tracker.sv
// Written-location bitmap and distinct-write counter.
// Count only moves on the first write to a location.
module ram_valid_tracker
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enb,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_addr_written,
  output logic [ADDR_W:0]   wr_count
);

  logic [DEPTH-1:0] bitmap_q, bitmap_d;
  cnt_t             cnt_q, cnt_d;

  always_comb begin
    bitmap_d = bitmap_q;
    cnt_d    = cnt_q;
    if (wr_enb) begin
      bitmap_d[wr_addr] = 1'b1;
      if (!bitmap_q[wr_addr]) begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitmap_q <= '0;
      cnt_q    <= '0;
    end else begin
      bitmap_q <= bitmap_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_addr_written = bitmap_q[rd_addr];
  assign wr_count        = cnt_q;

endmodule

// File: rtl/ram_dp_sync.sv
// Synchronous dual-port 16x8 RAM with registered read,
// uninitialised-read flag and configurable collision policy.
module ram_dp_sync
  import ram_pkg::*;
#(
  parameter bit WR_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enb,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_enb,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_uninit,
  output logic [ADDR_W:0]   wr_count
);

  data_t mem_q [DEPTH];
  data_t mem_d [DEPTH];
  data_t rd_data_q, rd_data_d;
  logic  rd_valid_q, rd_valid_d;
  logic  rd_uninit_q, rd_uninit_d;
  logic  run_q;
  logic  wr_go;
  logic  rd_go;
  logic  rd_written;
  logic  collide;

  // run_q holds off all updates on the edge that releases reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign wr_go   = wr_enb & run_q;
  assign rd_go   = rd_enb & run_q;
  assign collide = wr_go & rd_go & (wr_addr == rd_addr);

  ram_valid_tracker u_trk (
    .clk             (clk),
    .rst             (rst),
    .wr_enb          (wr_go),
    .wr_addr         (wr_addr),
    .rd_addr         (rd_addr),
    .rd_addr_written (rd_written),
    .wr_count        (wr_count)
  );

  always_comb begin
    mem_d       = mem_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_uninit_d = rd_uninit_q;
    if (wr_go) begin
      mem_d[wr_addr] = wr_data;
    end
    if (rd_go) begin
      rd_valid_d = 1'b1;
      if (WR_FIRST && collide) begin
        rd_data_d   = wr_data;
        rd_uninit_d = 1'b0;
      end else begin
        rd_data_d   = mem_q[rd_addr];
        rd_uninit_d = ~rd_written;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_uninit_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_uninit_q <= rd_uninit_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_uninit = rd_uninit_q;

endmodule

// File: tb/tb_ram_dp_sync.sv
// Bench for ram_dp_sync: write-first and read-first copies
// driven in lockstep against a reference model and scoreboard.
module tb_ram_dp_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_enb = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_enb = 1'b0;
  logic [3:0] rd_addr = '0;

  logic [7:0] d1_data, d0_data;
  logic       d1_valid, d0_valid;
  logic       d1_uninit, d0_uninit;
  logic [4:0] d1_cnt, d0_cnt;

  always #5 clk = ~clk;

  ram_dp_sync #(.WR_FIRST(1'b1)) u_wf1 (
    .clk(clk), .rst(rst),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr),
    .rd_data(d1_data), .rd_valid(d1_valid),
    .rd_uninit(d1_uninit), .wr_count(d1_cnt)
  );

  ram_dp_sync #(.WR_FIRST(1'b0)) u_wf0 (
    .clk(clk), .rst(rst),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr),
    .rd_data(d0_data), .rd_valid(d0_valid),
    .rd_uninit(d0_uninit), .wr_count(d0_cnt)
  );

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic       tbl;
    logic [7:0] t1;
    logic [7:0] t0;
  } vec_t;

  typedef struct {
    logic [7:0] d1;
    logic [7:0] d0;
    logic       u1;
    logic       u0;
    logic       tbl;
    logic [7:0] t1;
    logic [7:0] t0;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  logic [7:0] m_mem [16];
  logic       m_bm  [16];
  int         m_cnt;
  logic [7:0] last_d1, last_d0;
  logic       last_u1, last_u0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_bm[i]  = 1'b0;
    end
    m_cnt   = 0;
    last_d1 = '0;
    last_d0 = '0;
    last_u1 = 1'b0;
    last_u0 = 1'b0;
    sb.delete();
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] wa,
                              input logic [7:0] wd, input logic re,
                              input logic [3:0] ra, input logic tbl,
                              input logic [7:0] t1, input logic [7:0] t0);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.re = re; v.ra = ra;
    v.tbl = tbl; v.t1 = t1; v.t0 = t0;
    return v;
  endfunction

  task automatic cycle(input vec_t v);
    exp_t e;
    @(negedge clk);
    wr_enb  = v.we;
    wr_addr = v.wa;
    wr_data = v.wd;
    rd_enb  = v.re;
    rd_addr = v.ra;
    if (v.re) begin
      e.d0  = m_mem[v.ra];
      e.u0  = ~m_bm[v.ra];
      e.tbl = v.tbl;
      e.t1  = v.t1;
      e.t0  = v.t0;
      if (v.we && v.wa == v.ra) begin
        e.d1 = v.wd;
        e.u1 = 1'b0;
      end else begin
        e.d1 = e.d0;
        e.u1 = e.u0;
      end
      sb.push_back(e);
    end
    if (v.we) begin
      if (!m_bm[v.wa]) m_cnt++;
      m_bm[v.wa]  = 1'b1;
      m_mem[v.wa] = v.wd;
    end
    @(posedge clk);
    #1;
    chk("wr_count_wf1", int'(d1_cnt), m_cnt);
    chk("wr_count_wf0", int'(d0_cnt), m_cnt);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_valid_wf1", int'(d1_valid), 1);
      chk("rd_valid_wf0", int'(d0_valid), 1);
      chk("rd_data_wf1", int'(d1_data), int'(e.d1));
      chk("rd_data_wf0", int'(d0_data), int'(e.d0));
      chk("rd_uninit_wf1", int'(d1_uninit), int'(e.u1));
      chk("rd_uninit_wf0", int'(d0_uninit), int'(e.u0));
      if (e.tbl) begin
        chk("tbl_data_wf1", int'(d1_data), int'(e.t1));
        chk("tbl_data_wf0", int'(d0_data), int'(e.t0));
      end
      last_d1 = e.d1;
      last_d0 = e.d0;
      last_u1 = e.u1;
      last_u0 = e.u0;
    end else begin
      chk("idle_valid_wf1", int'(d1_valid), 0);
      chk("idle_valid_wf0", int'(d0_valid), 0);
      chk("hold_data_wf1", int'(d1_data), int'(last_d1));
      chk("hold_data_wf0", int'(d0_data), int'(last_d0));
      chk("hold_uninit_wf1", int'(d1_uninit), int'(last_u1));
      chk("hold_uninit_wf0", int'(d0_uninit), int'(last_u0));
    end
  endtask

  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    vecs.push_back(mk(0, 0, 8'h00, 1, 3, 1, 8'h00, 8'h00));
    vecs.push_back(mk(1, 2, 8'hA5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 2, 1, 8'hA5, 8'hA5));
    vecs.push_back(idle);
    for (int a = 0; a < 16; a++) begin
      vecs.push_back(mk(1, 4'(a), 8'(a * 8'h11), 0, 0, 0, 0, 0));
    end
    vecs.push_back(mk(1, 0, 8'hFF, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'hFF, 8'hFF));
    vecs.push_back(mk(0, 0, 8'h00, 1, 15, 1, 8'hFF, 8'hFF));
    vecs.push_back(mk(1, 5, 8'h11, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 8'h22, 1, 5, 1, 8'h22, 8'h11));
    vecs.push_back(mk(0, 0, 8'h00, 1, 5, 1, 8'h22, 8'h22));
    vecs.push_back(mk(1, 9, 8'h99, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 8'h3C, 1, 9, 1, 8'h99, 8'h99));
    vecs.push_back(mk(0, 0, 8'h00, 1, 7, 1, 8'h3C, 8'h3C));
    vecs.push_back(idle);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", int'(d1_valid | d0_valid), 0);
    chk("reset_data", int'(d1_data | d0_data), 0);
    chk("reset_uninit", int'(d1_uninit | d0_uninit), 0);
    chk("reset_count", int'(d1_cnt | d0_cnt), 0);

    @(negedge clk);
    rst = 1'b1;
    cycle(idle);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i]);
    end
    chk("full_count", int'(d1_cnt), 16);

    for (int a = 0; a < 6; a++) begin
      cycle(mk(0, 0, 0, 1, 4'(a), 0, 0, 0));
    end
    cycle(mk(0, 0, 0, 1, 6, 0, 0, 0));
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_valid_wf1", int'(d1_valid), 0);
    chk("midrst_valid_wf0", int'(d0_valid), 0);
    chk("midrst_data_wf1", int'(d1_data), 0);
    chk("midrst_data_wf0", int'(d0_data), 0);
    chk("midrst_count_wf1", int'(d1_cnt), 0);
    chk("midrst_count_wf0", int'(d0_cnt), 0);
    model_reset();

    @(negedge clk);
    rst     = 1'b1;
    rd_enb  = 1'b0;
    wr_enb  = 1'b0;
    cycle(idle);
    cycle(mk(0, 0, 0, 1, 2, 1, 8'h00, 8'h00));
    chk("post_rst_uninit", int'(d1_uninit & d0_uninit), 1);
    cycle(mk(0, 0, 0, 1, 9, 1, 8'h00, 8'h00));
    cycle(idle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
